// File: rtl/xillybus_loop_fifo_32.sv
// xillybus_loop_fifo_32
// 32-bit loopback FIFO between the Xillybus write_32 and read_32 streams.
// Words written by the host are buffered and returned on the read stream
// (standard non-FWFT timing: data appears the cycle after rden).
// Dropping the read-file open flushes the buffer.
// Optional feature macro: LOOP_FIFO_EOF_EN builds the read-side EOF state
// machine; without it user_r_read_32_eof is tied low.
module xillybus_loop_fifo_32 #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  bus_clk,
  input  logic                  trn_reset_n,
  input  logic                  user_w_write_32_wren,
  input  logic [31:0]           user_w_write_32_data,
  output logic                  user_w_write_32_full,
  input  logic                  user_w_write_32_open,
  input  logic                  user_r_read_32_rden,
  output logic [31:0]           user_r_read_32_data,
  output logic                  user_r_read_32_empty,
  output logic                  user_r_read_32_eof,
  input  logic                  user_r_read_32_open,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [31:0]           mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [31:0]           rd_data;
  logic                  r_open_q;
  logic                  full;
  logic                  empty;
  logic                  flush;
  logic                  do_wr;
  logic                  do_rd;

  // Status comes from the registered count only, never from the strobes.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // A falling read-open flushes everything; the flush cycle wins over any
  // read or write presented at the same time.
  assign flush = r_open_q & ~user_r_read_32_open;
  assign do_wr = user_w_write_32_wren & ~full  & ~flush;
  assign do_rd = user_r_read_32_rden  & ~empty & ~flush;

  assign user_w_write_32_full = full;
  assign user_r_read_32_empty = empty;
  assign user_r_read_32_data  = rd_data;
  assign fill_level           = count;

  // Storage array: written only, never reset (contents are don't-care after reset).
  always_ff @(posedge bus_clk) begin
    if (do_wr) begin
      mem[wptr] <= user_w_write_32_data;
    end
  end

  // Pointers, occupancy, read data register and read-open edge detector.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      r_open_q <= 1'b0;
    end else begin
      r_open_q <= user_r_read_32_open;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (do_wr) begin
          wptr <= wptr + 1'b1;
        end
        if (do_rd) begin
          rptr    <= rptr + 1'b1;
          rd_data <= mem[rptr];
        end
        case ({do_wr, do_rd})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef LOOP_FIFO_EOF_EN
  typedef enum logic [1:0] {
    EOF_IDLE   = 2'd0,
    EOF_ARMED  = 2'd1,
    EOF_SIGNAL = 2'd2
  } eof_state_t;

  eof_state_t eof_state;
  eof_state_t eof_state_next;
  logic       w_open_q;

  // EOF state register and write-open edge detector.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      eof_state <= EOF_IDLE;
      w_open_q  <= 1'b0;
    end else begin
      eof_state <= eof_state_next;
      w_open_q  <= user_w_write_32_open;
    end
  end

  // Arm on write-file close, signal once drained, disarm on reopen or flush.
  always_comb begin
    eof_state_next = eof_state;
    case (eof_state)
      EOF_IDLE: begin
        if (w_open_q && !user_w_write_32_open) begin
          eof_state_next = EOF_ARMED;
        end
      end
      EOF_ARMED: begin
        if (user_w_write_32_open || flush) begin
          eof_state_next = EOF_IDLE;
        end else if (empty) begin
          eof_state_next = EOF_SIGNAL;
        end
      end
      EOF_SIGNAL: begin
        if (user_w_write_32_open || flush) begin
          eof_state_next = EOF_IDLE;
        end
      end
      default: eof_state_next = EOF_IDLE;
    endcase
  end

  assign user_r_read_32_eof = (eof_state == EOF_SIGNAL) & empty;
`else
  // Without the EOF machine the write-open input has no consumer.
  logic unused_w_open;
  assign unused_w_open      = user_w_write_32_open;
  assign user_r_read_32_eof = 1'b0;
`endif

endmodule

// File: tb/tb_xillybus_loop_fifo_32.sv
// Self-checking bench for xillybus_loop_fifo_32 (DEPTH_LOG2 = 4).
module tb_xillybus_loop_fifo_32;

  localparam int DL2 = 4;

  logic          bus_clk = 1'b0;
  logic          trn_reset_n = 1'b1;
  logic          wren = 1'b0;
  logic [31:0]   wdata = '0;
  logic          full;
  logic          w_open = 1'b1;
  logic          rden = 1'b0;
  logic [31:0]   rdata;
  logic          empty;
  logic          eof;
  logic          r_open = 1'b1;
  logic [DL2:0]  fill;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   sb[$];

  xillybus_loop_fifo_32 #(.DEPTH_LOG2(DL2)) dut (
    .bus_clk              (bus_clk),
    .trn_reset_n          (trn_reset_n),
    .user_w_write_32_wren (wren),
    .user_w_write_32_data (wdata),
    .user_w_write_32_full (full),
    .user_w_write_32_open (w_open),
    .user_r_read_32_rden  (rden),
    .user_r_read_32_data  (rdata),
    .user_r_read_32_empty (empty),
    .user_r_read_32_eof   (eof),
    .user_r_read_32_open  (r_open),
    .fill_level           (fill)
  );

  always #5 bus_clk = ~bus_clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    wren  = 1'b1;
    wdata = d;
    sb.push_back(d);
    step();
    wren  = 1'b0;
  endtask

  task automatic rd(input string tag);
    logic [31:0] exp;
    rden = 1'b1;
    step();
    rden = 1'b0;
    exp = (sb.size() != 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    chk(tag, rdata, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_full"},  {31'd0, full},  32'd0);
    chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    chk({tag, "_eof"},   {31'd0, eof},   32'd0);
    chk({tag, "_data"},  rdata,          32'd0);
    chk({tag, "_fill"},  {27'd0, fill},  32'd0);
  endtask

  initial begin
    // Reset state, checked before any clock edge.
    #1 trn_reset_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    step();
    step();
    trn_reset_n = 1'b1;
    step();

    // Basic write 1..4 then read back.
    for (int i = 1; i <= 4; i++) begin
      wr(32'(i));
      chk("basic_fill_wr", {27'd0, fill}, 32'(i));
      chk("basic_empty_wr", {31'd0, empty}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      rd("basic_rd");
      chk("basic_fill_rd", {27'd0, fill}, 32'(3 - i));
    end
    chk("basic_empty_end", {31'd0, empty}, 32'd1);

    // Fill to full, overflow attempt dropped, read back in order.
    for (int i = 0; i < 16; i++) begin
      chk("fill_notfull", {31'd0, full}, 32'd0);
      wr(32'hC000_0000 + 32'(i * 7));
    end
    chk("full_set", {31'd0, full}, 32'd1);
    chk("full_fill", {27'd0, fill}, 32'd16);
    wren  = 1'b1;
    wdata = 32'hDEADBEEF;
    step();
    wren  = 1'b0;
    chk("overflow_fill", {27'd0, fill}, 32'd16);
    chk("overflow_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      rd("full_rd");
    end
    chk("full_drained_empty", {31'd0, empty}, 32'd1);
    chk("full_drained_full", {31'd0, full}, 32'd0);

    // Steady state at 8 words with simultaneous read/write, pointers wrap.
    for (int i = 0; i < 8; i++) begin
      wr(32'h0000_1000 + 32'(i));
    end
    for (int i = 0; i < 100; i++) begin
      logic [31:0] exp;
      wren  = 1'b1;
      rden  = 1'b1;
      wdata = 32'h0000_2000 + 32'(i);
      sb.push_back(wdata);
      step();
      exp = sb.pop_front();
      chk("stream_rd", rdata, exp);
      chk("stream_fill", {27'd0, fill}, 32'd8);
    end
    wren = 1'b0;
    rden = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd("stream_tail_rd");
    end
    chk("stream_empty", {31'd0, empty}, 32'd1);

    // Write-file close with data pending, then drain.
    for (int i = 0; i < 3; i++) begin
      wr(32'h0000_3000 + 32'(i));
    end
    w_open = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("eof_pending", {31'd0, eof}, 32'd0);
    end
    rd("eof_rd0");
    chk("eof_after_rd0", {31'd0, eof}, 32'd0);
    rd("eof_rd1");
    chk("eof_after_rd1", {31'd0, eof}, 32'd0);
    rd("eof_rd2");
`ifdef LOOP_FIFO_EOF_EN
    begin
      int n = 0;
      while (eof !== 1'b1 && n < 4) begin
        step();
        n++;
      end
      chk("eof_asserted", {31'd0, eof}, 32'd1);
      chk("eof_empty", {31'd0, empty}, 32'd1);
    end
`else
    step();
    step();
    chk("eof_tied_low", {31'd0, eof}, 32'd0);
    chk("eof_empty", {31'd0, empty}, 32'd1);
`endif
    w_open = 1'b1;
    step();
    chk("eof_cleared", {31'd0, eof}, 32'd0);

    // Read-file close flushes; the write in the flush cycle is discarded.
    for (int i = 0; i < 5; i++) begin
      wr(32'h0000_4000 + 32'(i));
    end
    chk("flush_pre_fill", {27'd0, fill}, 32'd5);
    r_open = 1'b0;
    wren   = 1'b1;
    wdata  = 32'h12345678;
    step();
    wren   = 1'b0;
    sb.delete();
    chk("flush_fill", {27'd0, fill}, 32'd0);
    chk("flush_empty", {31'd0, empty}, 32'd1);
    step();
    chk("flush_hold_fill", {27'd0, fill}, 32'd0);
    r_open = 1'b1;
    step();
    wr(32'h0000_0055);
    chk("post_flush_fill", {27'd0, fill}, 32'd1);
    rd("post_flush_rd");

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 6; i++) begin
      wr(32'h0000_5000 + 32'(i));
    end
    chk("prereset_fill", {27'd0, fill}, 32'd6);
    #3 trn_reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    sb.delete();
    #2 trn_reset_n = 1'b1;
    step();
    wr(32'hA5A5A5A5);
    chk("post_reset_fill", {27'd0, fill}, 32'd1);
    rd("post_reset_rd");
    chk("post_reset_empty", {31'd0, empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xillybus_loop_fifo_32.md
# xillybus_loop_fifo_32

Synchronous 32-bit FIFO on `bus_clk` directly downstream of the Xillybus core's `write_32` stream and directly upstream of its `read_32` stream. Host data written to the 32-bit write device file is buffered and returned on the 32-bit read device file, giving a host-visible loopback. The FIFO also generates the read-side end-of-file when the host closes the write file and the buffer has drained.

## Interface
Parameters:
- `DEPTH_LOG2`, default 9 — FIFO depth is 2^DEPTH_LOG2 words of 32 bits.

Ports:
- `bus_clk`  in  1 — single clock for all logic; this is the Xillybus core's `bus_clk` output.
- `trn_reset_n`  in  1 — reset; asynchronous, active-low.
- `user_w_write_32_wren`  in  1 — write strobe from the core.
- `user_w_write_32_data`  in  32 — write data from the core.
- `user_w_write_32_full`  out  1 — FIFO full, returned to the core.
- `user_w_write_32_open`  in  1 — host holds the write file open.
- `user_r_read_32_rden`  in  1 — read strobe from the core.
- `user_r_read_32_data`  out  32 — read data returned to the core.
- `user_r_read_32_empty`  out  1 — FIFO empty.
- `user_r_read_32_eof`  out  1 — end-of-file indication to the core.
- `user_r_read_32_open`  in  1 — host holds the read file open.
- `fill_level`  out  DEPTH_LOG2+1 — current word count.

## Operation
- Storage: 2^DEPTH_LOG2 × 32 memory.
  - Write and read pointers are DEPTH_LOG2 bits wide and wrap modulo the depth.
  - `count` is DEPTH_LOG2+1 bits: 0 .. 2^DEPTH_LOG2.
- Write: `wren & !full` stores the data at `wptr`, then `wptr++` and `count++`.
  - `wren` while full is a protocol violation: the word is dropped and there is no state change.
- Read: `rden & !empty` registers `mem[rptr]` into `user_r_read_32_data`, then `rptr++` and `count--`.
  - `rden` while empty is ignored; the data output holds its value.
- Simultaneous valid read and write: both pointers advance and `count` is unchanged.
- `full = (count == 2^DEPTH_LOG2)`, `empty = (count == 0)`, `fill_level = count`. All three derive from the registered count only; there is no combinational path from `wren`/`rden`.
- Flush:
  - A registered copy of `user_r_read_32_open` detects a 1→0 transition.
  - On the cycle after the fall, pointers and count clear to 0.
  - Flush has priority: a write or read in that cycle is discarded.
- EOF state machine, with states IDLE, ARMED, SIGNAL (only when `LOOP_FIFO_EOF_EN` is defined):
  - IDLE → ARMED when the registered `user_w_write_32_open` falls 1→0.
  - ARMED → SIGNAL when `count == 0`.
  - ARMED/SIGNAL → IDLE when `user_w_write_32_open` rises, or when the read-side flush occurs.
  - `user_r_read_32_eof = (state == SIGNAL) & empty`.

## Timing
- Reset values: `full` = 0, `empty` = 1, `eof` = 0, `user_r_read_32_data` = 0, `fill_level` = 0; pointers 0; EOF state IDLE.
- Write at edge N: `empty` deasserts and `fill_level` increments in the cycle after edge N.
  - Write-to-readable latency is 1 cycle.
- `rden` sampled at edge N: the data word is valid on `user_r_read_32_data` after edge N, during cycle N+1. This is standard (non-FWFT) Xillybus FIFO behaviour.
- `full` asserts in the cycle after the write that fills the last slot. The core never issues `wren` in a cycle where `full` is high.
- Pointer wrap: the write after `wptr = 2^DEPTH_LOG2-1` goes to address 0. `full` and `empty` remain exact across the wrap.
- EOF: `eof` asserts 2 cycles after the write-open fall when already empty (1 cycle registered open, 1 cycle state update). Otherwise it asserts 1 cycle after the read that empties the FIFO.
- Reset mid-transfer: all state clears immediately and asynchronously. Stored contents are lost; memory data is not cleared.

## Configuration
- `LOOP_FIFO_EOF_EN` defined: the EOF state machine is built, and `user_r_read_32_eof` behaves as in Operation.
- Not defined: no EOF logic is built, and `user_r_read_32_eof` is tied to 0. Reads on an empty FIFO then block in the host rather than returning EOF.

## Test plan
- Reset, then write 0x00000001..0x00000004 one per cycle, then 4 `rden` → data reads 1,2,3,4 in the cycle after each `rden`; `fill_level` goes 4→0; `empty` returns to 1.
- With DEPTH_LOG2=4, write 16 words → `full` = 1 after the 16th write.
  - A 17th `wren` with 0xDEADBEEF is dropped; `fill_level` stays 16.
  - Reading 16 words returns the original data in order.
- Hold the FIFO at 8 words and assert `wren` and `rden` together for 100 cycles with an incrementing pattern → `fill_level` stays 8, output order is preserved, and the pointers wrap cleanly.
- Write 3 words, then drop `user_w_write_32_open`:
  - `eof` stays 0 while data remains.
  - After the third read, `eof` = 1 with `empty` = 1.
  - Raising `user_w_write_32_open` clears `eof` within 1 cycle.
- Write 5 words, drop `user_r_read_32_open`, and assert `wren` with 0x12345678 in the flush cycle → after flush `fill_level` = 0, `empty` = 1, and the flush-cycle word is discarded.
- Pulse `trn_reset_n` low mid-stream at 6 words → all outputs return to their reset values with no clock edge required. After release, a new write/read of 0xA5A5A5A5 returns 0xA5A5A5A5.
